// File: rtl/odd_sequence_checker_if.sv
// Signal bundle between the odd-step counter harness and its receive-side checker.
// The master drives the sampled counter stream and its controls; the checker reports back.
interface odd_sequence_checker_if;
  logic       check_en;
  logic       gen_reset;
  logic       gen_enable;
  logic [3:0] counter_in;
  logic       clear_err;
  logic       locked;
  logic       mismatch;
  logic [7:0] err_count;
  logic [3:0] expected;

  modport master (
    output check_en, gen_reset, gen_enable, counter_in, clear_err,
    input  locked, mismatch, err_count, expected
  );

  modport slave (
    input  check_en, gen_reset, gen_enable, counter_in, clear_err,
    output locked, mismatch, err_count, expected
  );
endinterface

// File: rtl/odd_sequence_checker.sv
// Tracks the odd-step (+2 mod 16, reset to 1) counter stream, predicts each sample,
// and reports lock, one-cycle mismatch pulses and a saturating error count.
module odd_sequence_checker (
  input logic                   clock,
  input logic                   reset,
  odd_sequence_checker_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [3:0] PRED_RESET = 4'b0001;
  localparam logic [7:0] ERR_MAX    = 8'hFF;
  localparam logic [1:0] MISS_LIMIT = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] pred_q, pred_d;
  logic [1:0] miss_run_q, miss_run_d;
  logic [7:0] err_count_q, err_count_d;
  logic       locked_q;
  logic       mismatch_q;
  logic       err_evt;

  // Value the counter will show after this edge, given its own controls.
  function automatic logic [3:0] next_pred(input logic [3:0] base,
                                           input logic       g_reset,
                                           input logic       g_enable);
    if (g_reset)  return PRED_RESET;
    if (g_enable) return base + 4'd2;
    return base;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    miss_run_d = miss_run_q;
    err_evt    = 1'b0;

    if (!bus.check_en) begin
      state_d    = ST_IDLE;
      miss_run_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SYNC;
          miss_run_d = 2'd0;
        end
        ST_SYNC: begin
          miss_run_d = 2'd0;
          if (bus.gen_reset) begin
            pred_d  = PRED_RESET;
            state_d = ST_TRACK;
          end else if (bus.counter_in[0]) begin
            pred_d  = next_pred(bus.counter_in, 1'b0, bus.gen_enable);
            state_d = ST_TRACK;
          end else begin
            err_evt = 1'b1;
          end
        end
        ST_TRACK: begin
          pred_d = next_pred(pred_q, bus.gen_reset, bus.gen_enable);
          if (bus.counter_in != pred_q) begin
            err_evt = 1'b1;
            if (miss_run_q == MISS_LIMIT) begin
              state_d    = ST_SYNC;
              miss_run_d = 2'd0;
            end else begin
              miss_run_d = miss_run_q + 2'd1;
            end
          end else begin
            miss_run_d = 2'd0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          miss_run_d = 2'd0;
        end
      endcase
    end
  end

  // Clear wins over accumulation, but an error on the clearing edge still counts once.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.check_en) begin
      if (bus.clear_err)
        err_count_d = {7'd0, err_evt};
      else if (err_evt && (err_count_q != ERR_MAX))
        err_count_d = err_count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pred_q      <= PRED_RESET;
      miss_run_q  <= 2'd0;
      err_count_q <= 8'd0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      miss_run_q  <= miss_run_d;
      err_count_q <= err_count_d;
      locked_q    <= (state_d == ST_TRACK);
      mismatch_q  <= err_evt;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = pred_q;

endmodule
